// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI read-channel slave serving bursts from a 1-cycle-latency synchronous SRAM.
// Ports: clk_i/srst_i clock and sync reset; ar* request channel (arready registered, high in IDLE);
//        r* response channel fed from a 2-entry output FIFO; mem_en_o/mem_addr_o/mem_rdata_i SRAM read port.
module axi_rd_responder #(
   parameter int ID_W   = 4,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 12
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [ID_W-1:0]   arid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic [1:0]        arburst,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   output logic              mem_en_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   typedef enum logic {IDLE, BURST} state_t;
   localparam int WA_W = ADDR_W - 3;
   state_t st;
   logic [ID_W-1:0] id, t_id;
   logic [WA_W-1:0] waddr, inc, nxt;
   logic [7:0] cnt;
   logic [3:0] wmask;
   logic fixed, inflight, t_resp, t_last, oor, issue, pop, push, wp, rp;
   logic [1:0] fcnt;
   logic [ID_W-1:0] f_id [2];
   logic [DATA_W-1:0] f_data [2];
   logic f_resp [2];
   logic f_last [2];
   logic unused_lsb;
   assign unused_lsb = ^araddr[2:0];
   // the full word address is kept so beats running past the SRAM are flagged, not aliased
   assign oor = |waddr[WA_W-1:MEM_AW];
   assign pop = rvalid & rready;
   assign push = inflight;
   // a read issued last cycle still needs a FIFO slot, so it counts against the two entries
   assign issue = ~srst_i & (st == BURST) & ((3'(fcnt) + 3'(inflight) - 3'(pop)) < 3'd2);
   assign inc = waddr + WA_W'(1);
   assign nxt = fixed ? waddr : (|wmask ? ((waddr & ~WA_W'(wmask)) | (inc & WA_W'(wmask))) : inc);
   assign mem_en_o = issue & ~oor;
   assign mem_addr_o = mem_en_o ? waddr[MEM_AW-1:0] : '0;
   assign rvalid = fcnt != 2'd0;
   assign rid = rvalid ? f_id[rp] : '0;
   assign rdata = rvalid ? f_data[rp] : '0;
   assign rresp = rvalid ? {f_resp[rp], 1'b0} : 2'b00;
   assign rlast = rvalid & f_last[rp];
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         st <= IDLE;
         arready <= 1'b0;
         inflight <= 1'b0;
         fcnt <= 2'd0;
         wp <= 1'b0;
         rp <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            t_id <= id;
            t_resp <= oor;
            t_last <= cnt == 8'd0;
         end
         if (st == IDLE) begin
            arready <= ~(arvalid & arready);
            if (arvalid & arready) begin
               st <= BURST;
               id <= arid;
               waddr <= araddr[ADDR_W-1:3];
               cnt <= arlen;
               fixed <= arburst == 2'b00;
               // only power-of-two WRAP lengths get a window; anything else runs as INCR
               wmask <= (arburst == 2'b10 && arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ? arlen[3:0] : 4'd0;
            end
         end else if (issue) begin
            waddr <= nxt;
            cnt <= cnt - 8'd1;
            if (cnt == 8'd0) begin
               st <= IDLE;
               arready <= 1'b1;
            end
         end
         if (push) begin
            f_id[wp] <= t_id;
            f_data[wp] <= t_resp ? '0 : mem_rdata_i;
            f_resp[wp] <= t_resp;
            f_last[wp] <= t_last;
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         fcnt <= fcnt + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: tb/tb_axi_rd_responder.sv
// tb_axi_rd_responder: directed vector table plus hand sequences for axi_rd_responder.
module tb_axi_rd_responder;
   typedef struct packed {
      logic [1:0]       burst;
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [3:0]       id;
      logic [3:0][15:0] d;
      logic [3:0]       err;
   } vec_t;
   logic clk = 1'b0, srst_i = 1'b1;
   logic [3:0] arid = '0, rid;
   logic [31:0] araddr = '0;
   logic [7:0] arlen = '0;
   logic [1:0] arburst = '0, rresp;
   logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b1, mem_en_o;
   logic [63:0] rdata, mem_rdata_i;
   logic [11:0] mem_addr_o;
   logic [63:0] mem [4096];
   int passed = 0, total = 0, cyc = 0, en_cnt = 0;
   vec_t vt [9];
   axi_rd_responder dut (
      .clk_i(clk), .srst_i(srst_i), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_en_o) en_cnt <= en_cnt + 1;
      mem_rdata_i <= mem_en_o ? mem[mem_addr_o] : 64'hDEAD_BEEF;
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   function automatic vec_t mk(input logic [1:0] bu, input logic [31:0] a, input logic [7:0] l,
                               input logic [3:0] i, input int d0, d1, d2, d3, input logic [3:0] e);
      vec_t v;
      v.burst = bu; v.addr = a; v.len = l; v.id = i; v.err = e;
      v.d[0] = 16'(d0); v.d[1] = 16'(d1); v.d[2] = 16'(d2); v.d[3] = 16'(d3);
      return v;
   endfunction
   task automatic send_ar(input logic [1:0] bu, input logic [31:0] a, input logic [7:0] l, input logic [3:0] i);
      int t = 0;
      @(negedge clk);
      arvalid = 1'b1; arid = i; araddr = a; arlen = l; arburst = bu;
      while (!arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("ar_handshake", arready, 1);
      @(negedge clk);
      arvalid = 1'b0;
   endtask
   task automatic run_vec(input vec_t v, input int n);
      int base = en_cnt, ne = 0;
      send_ar(v.burst, v.addr, v.len, v.id);
      chk($sformatf("v%0d rvalid_t1", n), rvalid, 0);
      chk($sformatf("v%0d mem_en_t1", n), mem_en_o, !v.err[0]);
      @(negedge clk);
      chk($sformatf("v%0d rvalid_t2", n), rvalid, 0);
      for (int b = 0; b <= int'(v.len); b++) begin
         @(negedge clk);
         chk($sformatf("v%0d b%0d rvalid", n, b), rvalid, 1);
         chk($sformatf("v%0d b%0d rdata", n, b), rdata, 64'(v.d[b]));
         chk($sformatf("v%0d b%0d rresp", n, b), rresp, v.err[b] ? 2 : 0);
         chk($sformatf("v%0d b%0d rlast", n, b), rlast, b == int'(v.len));
         chk($sformatf("v%0d b%0d rid", n, b), rid, v.id);
         if (!v.err[b]) ne++;
      end
      @(negedge clk);
      chk($sformatf("v%0d rvalid_after", n), rvalid, 0);
      chk($sformatf("v%0d mem_en_count", n), en_cnt - base, ne);
   endtask
   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      for (int k = 0; k < 4096; k++) mem[k] = 64'(k);
      vt[0] = mk(2'b01, 32'h40,   8'd3, 4'h2, 8, 9, 10, 11, 4'b0000);
      vt[1] = mk(2'b10, 32'h58,   8'd3, 4'h1, 11, 8, 9, 10, 4'b0000);
      vt[2] = mk(2'b00, 32'h18,   8'd2, 4'h7, 3, 3, 3, 0, 4'b0000);
      vt[3] = mk(2'b01, 32'h7FF8, 8'd1, 4'h4, 4095, 0, 0, 0, 4'b0010);
      vt[4] = mk(2'b01, 32'h10,   8'd0, 4'h9, 2, 0, 0, 0, 4'b0000);
      vt[5] = mk(2'b10, 32'h38,   8'd1, 4'hA, 7, 6, 0, 0, 4'b0000);
      vt[6] = mk(2'b10, 32'h28,   8'd2, 4'hB, 5, 6, 7, 0, 4'b0000);
      vt[7] = mk(2'b01, 32'h8000, 8'd0, 4'hC, 0, 0, 0, 0, 4'b0001);
      vt[8] = mk(2'b01, 32'h07,   8'd1, 4'hD, 0, 1, 0, 0, 4'b0000);
      repeat (2) @(negedge clk);
      chk("rst arready", arready, 0);
      chk("rst rvalid", rvalid, 0);
      chk("rst rlast", rlast, 0);
      chk("rst rid", rid, 0);
      chk("rst rdata", rdata, 0);
      chk("rst rresp", rresp, 0);
      chk("rst mem_en", mem_en_o, 0);
      chk("rst mem_addr", mem_addr_o, 0);
      srst_i = 1'b0;
      @(negedge clk);
      chk("post_rst arready", arready, 1);
      for (int n = 0; n < 9; n++) run_vec(vt[n], n);
      begin
         int base, idx = 0;
         logic stalled = 1'b0;
         logic [63:0] pd;
         logic [3:0] pid;
         logic [1:0] presp;
         logic plast;
         base = en_cnt;
         send_ar(2'b01, 32'h0, 8'd7, 4'h6);
         for (int c = 0; c < 80 && idx < 8; c++) begin
            rready = (c % 3 == 0);
            #1;
            if (stalled) begin
               chk("bp stable rvalid", rvalid, 1);
               chk("bp stable rdata", rdata, pd);
               chk("bp stable rid", rid, pid);
               chk("bp stable rresp", rresp, presp);
               chk("bp stable rlast", rlast, plast);
            end
            if (rvalid && rready) begin
               chk($sformatf("bp b%0d rdata", idx), rdata, 64'(idx));
               chk($sformatf("bp b%0d rlast", idx), rlast, idx == 7);
               chk($sformatf("bp b%0d rid", idx), rid, 6);
               idx++;
            end
            chk("bp outstanding_le2", (en_cnt - base + int'(mem_en_o) - idx) <= 2, 1);
            stalled = rvalid && !rready;
            pd = rdata; pid = rid; presp = rresp; plast = rlast;
            @(negedge clk);
         end
         rready = 1'b1;
         chk("bp beats", idx, 8);
         repeat (2) @(negedge clk);
         chk("bp drained", rvalid, 0);
         chk("bp mem_en_count", en_cnt - base, 8);
      end
      begin
         int hs [2];
         int nh = 0;
         int iss [$];
         logic [3:0] ids [$];
         logic [63:0] dq [$];
         @(negedge clk);
         arvalid = 1'b1; arid = 4'd3; araddr = 32'h0; arlen = 8'd1; arburst = 2'b01;
         for (int c = 0; c < 30; c++) begin
            if (arvalid && arready && nh < 2) begin
               hs[nh] = cyc;
               nh++;
            end
            if (mem_en_o) iss.push_back(cyc);
            if (rvalid) begin
               ids.push_back(rid);
               dq.push_back(rdata);
            end
            @(negedge clk);
            if (nh == 1 && arid == 4'd3) begin
               arid = 4'd5;
               araddr = 32'h100;
            end
            if (nh == 2) arvalid = 1'b0;
         end
         chk("b2b handshakes", nh, 2);
         chk("b2b issues", iss.size(), 4);
         chk("b2b beats", ids.size(), 4);
         if (nh == 2 && iss.size() == 4) begin
            chk("b2b first issue", iss[0], hs[0] + 1);
            chk("b2b second ar", hs[1], iss[1] + 1);
            chk("b2b second issue", iss[2], hs[1] + 1);
         end
         if (ids.size() == 4) begin
            chk("b2b id0", ids[0], 3); chk("b2b id1", ids[1], 3);
            chk("b2b id2", ids[2], 5); chk("b2b id3", ids[3], 5);
            chk("b2b d0", dq[0], 0);   chk("b2b d1", dq[1], 1);
            chk("b2b d2", dq[2], 32);  chk("b2b d3", dq[3], 33);
         end
      end
      begin
         int seen = 0, t = 0;
         send_ar(2'b01, 32'h0, 8'd7, 4'h2);
         while (t < 20 && !(rvalid && seen == 2)) begin
            if (rvalid) seen++;
            @(negedge clk);
            t++;
         end
         chk("mid_rst reached beat2", rvalid && seen == 2, 1);
         chk("mid_rst beat2 data", rdata, 2);
         srst_i = 1'b1;
         @(negedge clk);
         chk("mid_rst rvalid", rvalid, 0);
         chk("mid_rst mem_en", mem_en_o, 0);
         chk("mid_rst arready", arready, 0);
         srst_i = 1'b0;
         @(negedge clk);
         chk("mid_rst arready_back", arready, 1);
         repeat (3) begin
            @(negedge clk);
            chk("mid_rst no_stale_beat", rvalid, 0);
         end
         run_vec(mk(2'b01, 32'h30, 8'd0, 4'h8, 6, 0, 0, 0, 4'b0000), 9);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
